// File: rtl/bp_profiler_ctrl.sv
// bp_profiler_ctrl: host command sequencer for the stall-reason counter bank.
// Ports: clk_i/reset_n_i clock and async active-low reset; cmd_v_i/cmd_op_i/
// cmd_clr_i/cmd_ready_o command handshake (START/STOP/CLEAR/DUMP);
// ctr_i live counters; prof_en_o/prof_clear_o bank control;
// data_v_o/data_o/data_idx_o/data_last_o/data_ready_i snapshot readout stream;
// busy_o high while clearing or dumping.
module bp_profiler_ctrl #(
  parameter int num_ctrs_p = 24,
  parameter int ctr_width_p = 32,
  localparam int idx_width_lp = (num_ctrs_p > 1) ? $clog2(num_ctrs_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic                              cmd_v_i,
  input  logic [1:0]                        cmd_op_i,
  input  logic                              cmd_clr_i,
  output logic                              cmd_ready_o,
  input  logic [num_ctrs_p*ctr_width_p-1:0] ctr_i,
  output logic                              prof_en_o,
  output logic                              prof_clear_o,
  output logic                              data_v_o,
  output logic [ctr_width_p-1:0]            data_o,
  output logic [idx_width_lp-1:0]           data_idx_o,
  output logic                              data_last_o,
  input  logic                              data_ready_i,
  output logic                              busy_o
);
  localparam logic [1:0] st_accept = 2'd0, st_clear = 2'd1, st_dump = 2'd2;
  localparam logic [1:0] op_start = 2'd0, op_stop = 2'd1, op_clear = 2'd2, op_dump = 2'd3;
  logic [1:0] state_q, state_d;
  logic run_q, run_d, clr_q, clr_d;
  logic [idx_width_lp-1:0] ptr_q, ptr_d;
  logic [ctr_width_p-1:0] snap_q [num_ctrs_p];
  logic cmd_acc, dump_acc, xfer, last;
  assign cmd_ready_o  = state_q == st_accept;
  assign cmd_acc      = cmd_v_i & cmd_ready_o;
  assign dump_acc     = cmd_acc & (cmd_op_i == op_dump);
  assign last         = ptr_q == idx_width_lp'(num_ctrs_p - 1);
  assign data_v_o     = state_q == st_dump;
  assign xfer         = data_v_o & data_ready_i;
  assign data_o       = snap_q[ptr_q];
  assign data_idx_o   = ptr_q;
  assign data_last_o  = data_v_o & last;
  assign busy_o       = ~cmd_ready_o;
  assign prof_clear_o = clr_q;
  // counting pauses during the clear pulse so the bank restarts from zero
  assign prof_en_o    = run_q & ~clr_q;
  always_comb begin
    run_d   = (cmd_acc & cmd_op_i == op_start) ? 1'b1 :
              (cmd_acc & cmd_op_i == op_stop)  ? 1'b0 : run_q;
    clr_d   = cmd_acc & (cmd_op_i == op_clear | (cmd_op_i == op_dump & cmd_clr_i));
    // ptr returns to 0 on the last beat so the next dump starts at index 0
    ptr_d   = xfer ? (last ? '0 : ptr_q + idx_width_lp'(1)) : ptr_q;
    state_d = (state_q == st_clear) ? st_accept :
              (xfer & last)         ? st_accept :
              !cmd_acc              ? state_q   :
              (cmd_op_i == op_clear) ? st_clear :
              (cmd_op_i == op_dump)  ? st_dump  : st_accept;
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q <= st_accept;
      run_q   <= 1'b0;
      clr_q   <= 1'b0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      clr_q   <= clr_d;
      ptr_q   <= ptr_d;
    end
  end
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int k = 0; k < num_ctrs_p; k++) snap_q[k] <= '0;
    end else if (dump_acc) begin
      for (int k = 0; k < num_ctrs_p; k++) snap_q[k] <= ctr_i[k*ctr_width_p +: ctr_width_p];
    end
  end
endmodule
